// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result handshake bundle for the pipelined adder.
interface pipelined_adder_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic in_sub;
  logic in_cin;
  logic [TAG_W-1:0] in_tag;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_sum;
  logic out_cout;
  logic out_ovf;
  logic [TAG_W-1:0] out_tag;
  modport master (
    output flush, in_valid, in_a, in_b, in_sub, in_cin, in_tag, out_ready,
    input in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );
  modport slave (
    input flush, in_valid, in_a, in_b, in_sub, in_cin, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep carry-chunked add/sub with valid/ready flow control and tag pass-through.
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int STAGES = 4,
  parameter int TAG_W = 6
) (
  input logic clk,
  input logic reset,
  pipelined_adder_if.slave bus
);
  localparam int C = WIDTH / STAGES;
  localparam int L = STAGES - 1;
  localparam int M = WIDTH - 1;
  logic [STAGES-1:0] vq, cq, sv, sc, nc;
  logic [STAGES:0] fr;
  logic [WIDTH-1:0] aq [STAGES];
  logic [WIDTH-1:0] bq [STAGES];
  logic [WIDTH-1:0] sq [STAGES];
  logic [WIDTH-1:0] sa [STAGES];
  logic [WIDTH-1:0] sb [STAGES];
  logic [WIDTH-1:0] ss [STAGES];
  logic [WIDTH-1:0] ns [STAGES];
  logic [TAG_W-1:0] tq [STAGES];
  logic [TAG_W-1:0] st [STAGES];
  // Register k holds the result with chunks 0..k resolved; chunk 0 is added on acceptance.
  always_comb begin
    sv[0] = bus.in_valid;
    sa[0] = bus.in_a;
    sb[0] = bus.in_sub ? ~bus.in_b : bus.in_b;
    sc[0] = bus.in_sub | bus.in_cin;
    ss[0] = '0;
    st[0] = bus.in_tag;
    for (int k = 1; k < STAGES; k++) begin
      sv[k] = vq[k-1];
      sa[k] = aq[k-1];
      sb[k] = bq[k-1];
      sc[k] = cq[k-1];
      ss[k] = sq[k-1];
      st[k] = tq[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      ns[k] = ss[k];
      {nc[k], ns[k][k*C +: C]} = {1'b0, sa[k][k*C +: C]} + {1'b0, sb[k][k*C +: C]} + {{C{1'b0}}, sc[k]};
    end
  end
  always_comb begin
    fr[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) fr[k] = !vq[k] || fr[k+1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      vq <= '0;
      cq <= '0;
      for (int k = 0; k < STAGES; k++) begin
        aq[k] <= '0;
        bq[k] <= '0;
        sq[k] <= '0;
        tq[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        vq[k] <= !bus.flush && (fr[k] ? sv[k] : vq[k]);
        if (fr[k] && sv[k]) begin
          aq[k] <= sa[k];
          bq[k] <= sb[k];
          sq[k] <= ns[k];
          cq[k] <= nc[k];
          tq[k] <= st[k];
        end
      end
    end
  end
  assign bus.in_ready = fr[0];
  assign bus.out_valid = vq[L];
  assign bus.out_sum = sq[L];
  assign bus.out_cout = cq[L];
  assign bus.out_tag = tq[L];
  assign bus.out_ovf = (aq[L][M] == bq[L][M]) && (sq[L][M] != aq[L][M]);
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed + random scoreboard bench over STAGES=4, 1 and 32 instances.
module tb_pipelined_adder;
  logic clk = 0;
  logic reset = 1;
  logic flush = 0;
  logic [31:0] op_a = 0, op_b = 0;
  logic op_sub = 0, op_cin = 0;
  logic [5:0] op_tag = 0;
  logic [2:0] iv = '0, ordy = '1;
  wire [2:0] ov, ir, oc, oo;
  wire [31:0] osum [3];
  wire [5:0] otag [3];
  int checks = 0, errors = 0;
  logic [39:0] sb [$];
  logic hold = 0;
  logic [39:0] held = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : d
    pipelined_adder_if #(.WIDTH(32), .TAG_W(6)) bus ();
    pipelined_adder #(.WIDTH(32), .STAGES(g == 0 ? 4 : g == 1 ? 1 : 32), .TAG_W(6)) dut (
      .clk(clk), .reset(reset), .bus(bus)
    );
    assign bus.flush = flush;
    assign bus.in_valid = iv[g];
    assign bus.in_a = op_a;
    assign bus.in_b = op_b;
    assign bus.in_sub = op_sub;
    assign bus.in_cin = op_cin;
    assign bus.in_tag = op_tag;
    assign bus.out_ready = ordy[g];
    assign ov[g] = bus.out_valid;
    assign ir[g] = bus.in_ready;
    assign oc[g] = bus.out_cout;
    assign oo[g] = bus.out_ovf;
    assign osum[g] = bus.out_sum;
    assign otag[g] = bus.out_tag;
  end
  task automatic chk(input string nm, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, o, e);
    end
  endtask
  // Reference: {tag, ovf, cout, sum}; overflow from exact signed arithmetic.
  function automatic logic [39:0] model(logic [31:0] a, logic [31:0] b, logic s, logic c, logic [5:0] t);
    logic [32:0] r;
    longint v;
    logic f;
    r = {1'b0, a} + {1'b0, s ? ~b : b} + {32'b0, s | c};
    v = s ? longint'($signed(a)) - longint'($signed(b)) : longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    f = (v > 64'sd2147483647) || (v < -64'sd2147483648);
    return {t, f, r[32], r[31:0]};
  endfunction
  always @(negedge clk) begin
    logic [39:0] cur;
    cur = {otag[0], oo[0], oc[0], osum[0]};
    if (hold) chk("hold", {ov[0], cur}, {1'b1, held});
    hold = ov[0] && !ordy[0] && !reset && !flush;
    held = cur;
    if (reset || flush) sb.delete();
    else begin
      if (ov[0] && ordy[0]) begin
        if (sb.size() == 0) chk("sb_extra", ov[0], 0);
        else chk("res", cur, sb.pop_front());
      end
      if (iv[0] && ir[0]) sb.push_back(model(op_a, op_b, op_sub, op_cin, op_tag));
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic setop(input logic [31:0] a, input logic [31:0] b, input logic s, input logic c, input logic [5:0] t);
    op_a = a;
    op_b = b;
    op_sub = s;
    op_cin = c;
    op_tag = t;
  endtask
  task automatic lat(input int dn, input logic [31:0] a, input logic [31:0] b, input logic s, input logic c,
                     input logic [5:0] t, input int en, input logic [33:0] er, input string nm);
    int n;
    ordy[dn] = 1;
    setop(a, b, s, c, t);
    iv[dn] = 1;
    step();
    iv[dn] = 0;
    n = 1;
    while (!ov[dn] && n < 64) begin
      step();
      n++;
    end
    chk({nm, "_lat"}, n, en);
    chk({nm, "_res"}, {oo[dn], oc[dn], osum[dn]}, er);
    step();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int idx, lows, acc;
    logic took, nv;
    repeat (2) step();
    reset = 0;
    for (int k = 0; k < 3; k++)
      chk("rst_init", {ov[k], osum[k], oc[k], oo[k], otag[k], ir[k]}, {1'b0, 32'b0, 1'b0, 1'b0, 6'b0, 1'b1});
    lat(0, 32'hFFFFFFFF, 32'h1, 0, 0, 6'd1, 4, {1'b0, 1'b1, 32'h0}, "wrap");
    lat(0, 32'h7FFFFFFF, 32'h1, 0, 0, 6'd2, 4, {1'b1, 1'b0, 32'h80000000}, "povf");
    lat(0, 32'h80000000, 32'h1, 1, 0, 6'd3, 4, {1'b1, 1'b1, 32'h7FFFFFFF}, "novf");
    lat(0, 32'd5, 32'd7, 1, 1, 6'd4, 4, {1'b0, 1'b0, 32'hFFFFFFFE}, "borrow");
    lat(0, 32'd3, 32'd4, 0, 1, 6'd5, 4, {1'b0, 1'b0, 32'd8}, "cin");
    idx = 0;
    lows = 0;
    for (int cyc = 0; cyc < 60 && !(idx == 10 && sb.size() == 0); cyc++) begin
      iv[0] = idx < 10;
      setop($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 6'(idx + 1));
      ordy[0] = !(cyc >= 2 && cyc <= 9);
      #1;
      chk("bp_rdy", ir[0], !(sb.size() == 4 && !ordy[0]));
      if (!ir[0]) lows++;
      @(negedge clk);
      if (iv[0] && ir[0]) idx++;
      step();
    end
    iv[0] = 0;
    ordy[0] = 1;
    chk("bp_fell", lows > 0, 1);
    chk("bp_sent", idx, 10);
    chk("bp_left", sb.size(), 0);
    for (int i = 0; i < 3; i++) begin
      setop(32'(i + 10), 32'(i), 0, 0, 6'(20 + i));
      iv[0] = 1;
      step();
    end
    setop(32'd99, 32'd1, 0, 0, 6'd30);
    flush = 1;
    step();
    flush = 0;
    iv[0] = 0;
    chk("fl_ov", ov[0], 0);
    nv = 0;
    repeat (6) begin
      step();
      nv |= ov[0];
    end
    chk("fl_none", nv, 0);
    lat(0, 32'd1, 32'd1, 0, 0, 6'd31, 4, {1'b0, 1'b0, 32'd2}, "fl_after");
    ordy = '1;
    iv = '1;
    for (int i = 0; i < 5; i++) begin
      setop($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 6'(40 + i));
      step();
    end
    reset = 1;
    step();
    reset = 0;
    iv = '0;
    for (int k = 0; k < 3; k++)
      chk("rst_mid", {ov[k], osum[k], oc[k], oo[k], otag[k], ir[k]}, {1'b0, 32'b0, 1'b0, 1'b0, 6'b0, 1'b1});
    lat(1, 32'h12345678, 32'h11111111, 0, 0, 6'd7, 1, {1'b0, 1'b0, 32'h23456789}, "s1");
    lat(2, 32'h0, 32'h1, 1, 0, 6'd8, 32, {1'b0, 1'b0, 32'hFFFFFFFF}, "s32");
    lat(0, 32'h0, 32'h0, 0, 1, 6'd9, 4, {1'b0, 1'b0, 32'd1}, "s4");
    acc = 0;
    took = 0;
    for (int cyc = 0; cyc < 40000 && acc < 10000; cyc++) begin
      if (!iv[0] || took) begin
        iv[0] = $urandom_range(3) != 0;
        setop($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 6'($urandom));
      end
      ordy[0] = $urandom_range(9) < 7;
      @(negedge clk);
      took = iv[0] && ir[0];
      if (took) acc++;
      step();
    end
    iv[0] = 0;
    ordy[0] = 1;
    for (int i = 0; i < 100 && sb.size() > 0; i++) step();
    chk("rnd_cnt", acc, 10000);
    chk("rnd_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
